// File: rtl/ct_f_spsram_1024x32_ctrl_pkg.sv
// Shared types and helpers for the two-requester 1024x32 SRAM controller.
// State encoding, default geometry and byte-enable to WEN expansion.
package ct_f_spsram_1024x32_ctrl_pkg;

    localparam int unsigned AW_DEF = 10;
    localparam int unsigned DW_DEF = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Active-low per-bit write enable from active-high byte enables.
    function automatic logic [31:0] be2wen(input logic [3:0] be);
        logic [31:0] wen;
        for (int k = 0; k < 4; k++) begin
            wen[8*k +: 8] = {8{~be[k]}};
        end
        return wen;
    endfunction

endpackage

// File: rtl/ct_f_spsram_1024x32_ctrl_arb.sv
// Two-way round-robin arbiter; the pointer register lives in the caller.
// ptr_i = 0 favours requester 0 when both are valid.
module ct_f_spsram_rr_arb2 (
    input  logic       en_i,
    input  logic [1:0] vld_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       ptr_d_o
);

    always_comb begin
        gnt_o   = 2'b00;
        ptr_d_o = ptr_i;
        if (en_i) begin
            if (vld_i == 2'b11) begin
                gnt_o = ptr_i ? 2'b10 : 2'b01;
            end else begin
                gnt_o = vld_i;
            end
        end
        if (gnt_o[0]) begin
            ptr_d_o = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d_o = 1'b0;
        end
    end

endmodule

// File: rtl/ct_f_spsram_1024x32_ctrl.sv
// Shares one single-port 1024x32 SRAM between two requesters.
// Zero-fill sweep after reset, then round-robin read/byte-write service.
module ct_f_spsram_1024x32_ctrl
    import ct_f_spsram_1024x32_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = AW_DEF,
    parameter int unsigned DATA_WIDTH = DW_DEF,
    parameter bit          INIT_EN    = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  p0_req_vld,
    output logic                  p0_req_rdy,
    input  logic                  p0_req_wr,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    input  logic [3:0]            p0_req_be,
    output logic                  p0_rsp_vld,
    output logic [DATA_WIDTH-1:0] p0_rsp_data,
    input  logic                  p1_req_vld,
    output logic                  p1_req_rdy,
    input  logic                  p1_req_wr,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    input  logic [3:0]            p1_req_be,
    output logic                  p1_rsp_vld,
    output logic [DATA_WIDTH-1:0] p1_rsp_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  rr_q, rr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [1:0]            rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp0_q, rsp1_q;
    logic [1:0]            gnt;
    logic                  run;
    logic                  m_wr;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [3:0]            m_be;

    assign run = (state_q == ST_RUN) && !RST;

    ct_f_spsram_rr_arb2 u_arb (
        .en_i    (run),
        .vld_i   ({p1_req_vld, p0_req_vld}),
        .ptr_i   (rr_q),
        .gnt_o   (gnt),
        .ptr_d_o (rr_d)
    );

    assign m_wr    = gnt[1] ? p1_req_wr    : p0_req_wr;
    assign m_addr  = gnt[1] ? p1_req_addr  : p0_req_addr;
    assign m_wdata = gnt[1] ? p1_req_wdata : p0_req_wdata;
    assign m_be    = gnt[1] ? p1_req_be    : p0_req_be;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rsp_vld_d = 2'b00;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = addr_q;
        sram_d    = wdat_q;
        if (!RST) begin
            unique case (state_q)
                ST_INIT: begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    sram_a    = cnt_q[ADDR_WIDTH-1:0];
                    sram_d    = '0;
                    addr_d    = cnt_q[ADDR_WIDTH-1:0];
                    wdat_d    = '0;
                    cnt_d     = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    if (cnt_d[ADDR_WIDTH]) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (|gnt) begin
                        sram_cen = 1'b0;
                        sram_a   = m_addr;
                        addr_d   = m_addr;
                        if (m_wr) begin
                            sram_d = m_wdata;
                            wdat_d = m_wdata;
                            // Empty byte mask still handshakes but leaves the array alone.
                            if (|m_be) begin
                                sram_gwen = 1'b0;
                                sram_wen  = be2wen(m_be);
                            end
                        end else begin
                            rsp_vld_d = gnt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= INIT_EN ? ST_INIT : ST_RUN;
            cnt_q     <= '0;
            rr_q      <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
            rsp_vld_q <= 2'b00;
            rsp0_q    <= '0;
            rsp1_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            rsp_vld_q <= rsp_vld_d;
            if (rsp_vld_q[0]) begin
                rsp0_q <= sram_q;
            end
            if (rsp_vld_q[1]) begin
                rsp1_q <= sram_q;
            end
        end
    end

    assign p0_req_rdy  = gnt[0];
    assign p1_req_rdy  = gnt[1];
    assign p0_rsp_vld  = rsp_vld_q[0];
    assign p1_rsp_vld  = rsp_vld_q[1];
    assign p0_rsp_data = rsp_vld_q[0] ? sram_q : rsp0_q;
    assign p1_rsp_data = rsp_vld_q[1] ? sram_q : rsp1_q;
    assign init_done   = run;

endmodule

// File: tb/tb_ct_f_spsram_1024x32_ctrl.sv
// Bench for the shared SRAM controller: SRAM model, reference memory,
// per-port response scoreboards, a grant table and reset sequences.
module tb_ct_f_spsram_1024x32_ctrl;

    typedef struct packed {
        logic        vld;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct packed {
        req_t       p0;
        req_t       p1;
        logic [1:0] rdy;
        logic       gwen;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        p0_req_vld, p0_req_rdy, p0_req_wr, p0_rsp_vld;
    logic [9:0]  p0_req_addr;
    logic [31:0] p0_req_wdata, p0_rsp_data;
    logic [3:0]  p0_req_be;
    logic        p1_req_vld, p1_req_rdy, p1_req_wr, p1_rsp_vld;
    logic [9:0]  p1_req_addr;
    logic [31:0] p1_req_wdata, p1_rsp_data;
    logic [3:0]  p1_req_be;
    logic        init_done, sram_cen, sram_gwen;
    logic [9:0]  sram_a;
    logic [31:0] sram_wen, sram_d, sram_q;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] last0, last1;
    vec_t        vt [21];

    always #5 CLK = ~CLK;

    ct_f_spsram_1024x32_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .p0_req_vld   (p0_req_vld),
        .p0_req_rdy   (p0_req_rdy),
        .p0_req_wr    (p0_req_wr),
        .p0_req_addr  (p0_req_addr),
        .p0_req_wdata (p0_req_wdata),
        .p0_req_be    (p0_req_be),
        .p0_rsp_vld   (p0_rsp_vld),
        .p0_rsp_data  (p0_rsp_data),
        .p1_req_vld   (p1_req_vld),
        .p1_req_rdy   (p1_req_rdy),
        .p1_req_wr    (p1_req_wr),
        .p1_req_addr  (p1_req_addr),
        .p1_req_wdata (p1_req_wdata),
        .p1_req_be    (p1_req_be),
        .p1_rsp_vld   (p1_rsp_vld),
        .p1_rsp_data  (p1_rsp_data),
        .init_done    (init_done),
        .sram_a       (sram_a),
        .sram_cen     (sram_cen),
        .sram_gwen    (sram_gwen),
        .sram_wen     (sram_wen),
        .sram_d       (sram_d),
        .sram_q       (sram_q)
    );

    // SRAM macro model: registered read, bit-masked write, old data on collision.
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            end
            sram_q <= mem[sram_a];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic req_t R(input logic [9:0] a);
        req_t r;
        r = '0;
        r.vld = 1'b1;
        r.addr = a;
        return r;
    endfunction

    function automatic req_t W(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        req_t r;
        r.vld = 1'b1;
        r.wr = 1'b1;
        r.addr = a;
        r.wdata = d;
        r.be = be;
        return r;
    endfunction

    function automatic req_t I();
        req_t r;
        r = '0;
        return r;
    endfunction

    function automatic vec_t V(input req_t a, input req_t b, input logic [1:0] r, input logic g);
        vec_t v;
        v.p0 = a;
        v.p1 = b;
        v.rdy = r;
        v.gwen = g;
        return v;
    endfunction

    task automatic drive(input req_t a, input req_t b);
        p0_req_vld = a.vld;
        p0_req_wr = a.wr;
        p0_req_addr = a.addr;
        p0_req_wdata = a.wdata;
        p0_req_be = a.be;
        p1_req_vld = b.vld;
        p1_req_wr = b.wr;
        p1_req_addr = b.addr;
        p1_req_wdata = b.wdata;
        p1_req_be = b.be;
    endtask

    task automatic ref_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int k = 0; k < 4; k++) begin
            if (be[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
        end
    endtask

    // Scoreboard: pop on responses, push on read handshakes, track writes.
    always @(negedge CLK) begin
        logic [31:0] e;
        if (RST) begin
            q0.delete();
            q1.delete();
            last0 = '0;
            last1 = '0;
            foreach (ref_mem[i]) ref_mem[i] = '0;
        end else begin
            if (p0_rsp_vld) begin
                chk("p0 rsp pending", q0.size(), 1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    chk("p0 rsp data", p0_rsp_data, e);
                end
                last0 = p0_rsp_data;
            end else if (init_done) begin
                chk("p0 rsp missing", q0.size(), 0);
                q0.delete();
                chk("p0 rsp hold", p0_rsp_data, last0);
            end
            if (p1_rsp_vld) begin
                chk("p1 rsp pending", q1.size(), 1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    chk("p1 rsp data", p1_rsp_data, e);
                end
                last1 = p1_rsp_data;
            end else if (init_done) begin
                chk("p1 rsp missing", q1.size(), 0);
                q1.delete();
                chk("p1 rsp hold", p1_rsp_data, last1);
            end
            if (p0_req_vld && p0_req_rdy) begin
                if (p0_req_wr) ref_write(p0_req_addr, p0_req_wdata, p0_req_be);
                else q0.push_back(ref_mem[p0_req_addr]);
            end
            if (p1_req_vld && p1_req_rdy) begin
                if (p1_req_wr) ref_write(p1_req_addr, p1_req_wdata, p1_req_be);
                else q1.push_back(ref_mem[p1_req_addr]);
            end
        end
    end

    task automatic chk_rst(input string tag);
        chk({tag, " cen/gwen"}, {sram_cen, sram_gwen}, 2'b11);
        chk({tag, " wen"}, sram_wen, 32'hFFFF_FFFF);
        chk({tag, " a"}, sram_a, 10'h000);
        chk({tag, " d"}, sram_d, 32'h0);
        chk({tag, " rdy/rsp/done"}, {p1_req_rdy, p0_req_rdy, p1_rsp_vld, p0_rsp_vld, init_done}, 5'b0);
        chk({tag, " rsp data"}, {p1_rsp_data, p0_rsp_data}, 64'h0);
    endtask

    // Checks one sweep cycle per negedge; leaves the caller at the last checked negedge.
    task automatic run_init(input int ncyc);
        int bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge CLK);
            if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 32'h0 ||
                sram_d !== 32'h0 || sram_a !== 10'(i) || p0_req_rdy !== 1'b0 ||
                p1_req_rdy !== 1'b0 || init_done !== 1'b0) begin
                bad++;
            end
        end
        chk("init sweep bad cycles", bad, 0);
    endtask

    initial begin
        foreach (mem[i]) mem[i] = $urandom;
        sram_q = $urandom;
        drive(I(), I());

        vt[0]  = V(I(), W(10'h2A5, 32'hDEADBEEF, 4'hF), 2'b10, 1'b0);
        vt[1]  = V(I(), R(10'h2A5), 2'b10, 1'b1);
        vt[2]  = V(W(10'h100, 32'h1000_0100, 4'hF), W(10'h200, 32'h2000_0200, 4'hF), 2'b01, 1'b0);
        vt[3]  = V(W(10'h101, 32'h1000_0101, 4'hF), W(10'h200, 32'h2000_0200, 4'hF), 2'b10, 1'b0);
        vt[4]  = V(W(10'h101, 32'h1000_0101, 4'hF), W(10'h201, 32'h2000_0201, 4'hF), 2'b01, 1'b0);
        vt[5]  = V(W(10'h102, 32'h1000_0102, 4'hF), W(10'h201, 32'h2000_0201, 4'hF), 2'b10, 1'b0);
        vt[6]  = V(W(10'h102, 32'h1000_0102, 4'hF), W(10'h202, 32'h2000_0202, 4'hF), 2'b01, 1'b0);
        vt[7]  = V(I(), W(10'h202, 32'h2000_0202, 4'hF), 2'b10, 1'b0);
        vt[8]  = V(R(10'h100), R(10'h200), 2'b01, 1'b1);
        vt[9]  = V(R(10'h101), R(10'h200), 2'b10, 1'b1);
        vt[10] = V(R(10'h101), R(10'h201), 2'b01, 1'b1);
        vt[11] = V(R(10'h102), R(10'h201), 2'b10, 1'b1);
        vt[12] = V(R(10'h102), R(10'h202), 2'b01, 1'b1);
        vt[13] = V(I(), R(10'h202), 2'b10, 1'b1);
        vt[14] = V(W(10'h010, 32'hA5A5A5A5, 4'hF), I(), 2'b01, 1'b0);
        vt[15] = V(W(10'h010, 32'h11223344, 4'b0101), I(), 2'b01, 1'b0);
        vt[16] = V(R(10'h010), I(), 2'b01, 1'b1);
        vt[17] = V(I(), W(10'h005, 32'h12345678, 4'hF), 2'b10, 1'b0);
        vt[18] = V(W(10'h005, 32'hFFFFFFFF, 4'h0), I(), 2'b01, 1'b1);
        vt[19] = V(R(10'h005), I(), 2'b01, 1'b1);
        vt[20] = V(I(), I(), 2'b00, 1'b1);

        repeat (3) @(posedge CLK);
        #1;
        chk_rst("por");

        drive(R(10'h3FF), I());
        RST = 1'b0;
        run_init(1024);
        @(negedge CLK);
        chk("first run init_done", init_done, 1'b1);
        chk("first run grant", {p1_req_rdy, p0_req_rdy}, 2'b01);
        chk("first run a/cen", {sram_a, sram_cen, sram_gwen}, {10'h3FF, 1'b0, 1'b1});
        @(posedge CLK);
        #1;

        for (int i = 0; i < 21; i++) begin
            drive(vt[i].p0, vt[i].p1);
            @(negedge CLK);
            chk($sformatf("vec%0d grant", i), {p1_req_rdy, p0_req_rdy}, vt[i].rdy);
            chk($sformatf("vec%0d gwen", i), sram_gwen, vt[i].gwen);
            chk($sformatf("vec%0d cen", i), sram_cen, ~|vt[i].rdy);
            @(posedge CLK);
            #1;
        end

        drive(R(10'h100), I());
        @(negedge CLK);
        chk("pre-reset grant", {p1_req_rdy, p0_req_rdy}, 2'b01);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        drive(I(), I());
        #1;
        chk_rst("run rst");
        @(negedge CLK);
        chk("run rst rsp dropped", {p1_rsp_vld, p0_rsp_vld}, 2'b00);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        run_init(10'h200);
        @(negedge CLK);
        chk("mid init a", sram_a, 10'h200);
        #1;
        RST = 1'b1;
        #1;
        chk_rst("init rst");
        @(posedge CLK);
        #1;
        drive(I(), R(10'h100));
        RST = 1'b0;
        run_init(1024);
        @(negedge CLK);
        chk("reinit done", init_done, 1'b1);
        chk("reinit grant", {p1_req_rdy, p0_req_rdy}, 2'b10);
        @(posedge CLK);
        #1;
        drive(I(), I());
        @(negedge CLK);
        chk("reinit rsp vld", p1_rsp_vld, 1'b1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("scoreboard drained", q0.size() + q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
